// File: rtl/des_spi_pkg.sv
// Shared definitions for the DES SPI frame sequencer: opcodes, FSM state
// encoding and the layout of the status word returned when no result is pending.
package des_spi_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_KEY = 8'hA5;
  localparam logic [7:0] OP_ENC = 8'h3C;
  localparam logic [7:0] OP_DEC = 8'hC3;
  localparam logic [7:0] OP_CLR = 8'hE0;

  localparam logic [7:0] STATUS_TAG = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_KEY  = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_START     = 3'd3,
    ST_BUSY      = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic key_valid;
    logic result_valid;
    logic err_timeout;
    logic err_proto;
  } seq_flags_t;

  // Tag in [63:56], state in [55:53], flags in [52:49], zero below.
  function automatic logic [63:0] pack_status(input seq_state_t st, input seq_flags_t fl);
    return {STATUS_TAG, st, fl, 49'd0};
  endfunction

endpackage

// File: rtl/des_spi_seq_if.sv
// Bundle of the SPI-slave word interface and the DES core load/result interface
// seen by the sequencer; master is the sequencer side, slave the SPI/core side.
interface des_spi_seq_if;

  logic        cs_n;
  logic [63:0] rx_word;
  logic [63:0] tx_word;
  logic [63:0] des_key;
  logic [63:0] des_block;
  logic        des_decrypt;
  logic        des_start;
  logic        des_done;
  logic [63:0] des_result;

  modport master (
    input  cs_n,
    input  rx_word,
    output tx_word,
    output des_key,
    output des_block,
    output des_decrypt,
    output des_start,
    input  des_done,
    input  des_result
  );

  modport slave (
    output cs_n,
    output rx_word,
    input  tx_word,
    input  des_key,
    input  des_block,
    input  des_decrypt,
    input  des_start,
    output des_done,
    output des_result
  );

endinterface

// File: rtl/des_spi_seq_spi_frame_tracker.sv
// Counts SCLK rises inside a chip-select window and flags a complete 64-bit
// frame until the sequencer consumes it.
module spi_frame_tracker #(
  parameter int CNT_W = 7
) (
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic consume,
  output logic frame_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(63);

  logic [CNT_W-1:0] bit_cnt_reg;
  logic             frame_done_reg;

  // Cleared asynchronously by cs_n high, matching the SPI receiver's framing.
  always_ff @(posedge sclk or negedge rst or posedge cs_n) begin
    if (!rst) begin
      bit_cnt_reg <= '0;
    end else if (cs_n) begin
      bit_cnt_reg <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  // Deselect does not drop a completed frame; only consumption does.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      frame_done_reg <= 1'b0;
    end else if (!cs_n && (bit_cnt_reg == LAST_BIT)) begin
      frame_done_reg <= 1'b1;
    end else if (consume) begin
      frame_done_reg <= 1'b0;
    end
  end

  assign frame_done = frame_done_reg;

endmodule

// File: rtl/des_spi_seq.sv
// Frame-level sequencer between the SPI slave and the DES core: decodes frames
// as commands/key/data, runs the core and returns the result or a status word.
module des_spi_seq
  import des_spi_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic           rst,
  input  logic           sclk,
  des_spi_seq_if.master  bus,
  output logic           busy,
  output logic           err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic        frame_done;
  logic        consume;
  logic [7:0]  opcode;

  seq_state_t       state_reg;
  logic [63:0]      key_reg;
  logic [63:0]      block_reg;
  logic [63:0]      result_reg;
  logic             decrypt_reg;
  logic             start_reg;
  logic             key_valid_reg;
  logic             result_valid_reg;
  logic             err_timeout_reg;
  logic             err_proto_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  seq_flags_t       flags;

  // A completed frame is decoded on the very next rise, whatever that rise is.
  assign consume = frame_done;
  assign opcode  = bus.rx_word[63:56];

  spi_frame_tracker #(
    .CNT_W (CNT_W)
  ) u_frame_tracker (
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (bus.cs_n),
    .consume    (consume),
    .frame_done (frame_done)
  );

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      key_reg          <= '0;
      block_reg        <= '0;
      result_reg       <= '0;
      decrypt_reg      <= 1'b0;
      start_reg        <= 1'b0;
      key_valid_reg    <= 1'b0;
      result_valid_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_proto_reg    <= 1'b0;
      tmo_cnt_reg      <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (consume) begin
            // Any frame seen here counts as the read of a pending result.
            result_valid_reg <= 1'b0;
            case (opcode)
              OP_NOP: state_reg <= ST_IDLE;
              OP_KEY: state_reg <= ST_WAIT_KEY;
              OP_ENC, OP_DEC: begin
                if (key_valid_reg) begin
                  state_reg   <= ST_WAIT_DATA;
                  decrypt_reg <= (opcode == OP_DEC);
                end else begin
                  err_proto_reg <= 1'b1;
                end
              end
              OP_CLR: begin
                err_timeout_reg <= 1'b0;
                err_proto_reg   <= 1'b0;
              end
              default: err_proto_reg <= 1'b1;
            endcase
          end
        end

        ST_WAIT_KEY: begin
          if (consume) begin
            key_reg       <= bus.rx_word;
            key_valid_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        ST_WAIT_DATA: begin
          if (consume) begin
            block_reg <= bus.rx_word;
            start_reg <= 1'b1;
            state_reg <= ST_START;
          end
        end

        ST_START: begin
          tmo_cnt_reg <= '0;
          state_reg   <= ST_BUSY;
          if (consume) begin
            err_proto_reg <= 1'b1;
          end
        end

        ST_BUSY: begin
          // The core keeps running; a stray frame only flags a protocol error.
          if (consume) begin
            err_proto_reg <= 1'b1;
          end
          if (bus.des_done) begin
            result_reg       <= bus.des_result;
            result_valid_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            err_timeout_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign flags.key_valid    = key_valid_reg;
  assign flags.result_valid = result_valid_reg;
  assign flags.err_timeout  = err_timeout_reg;
  assign flags.err_proto    = err_proto_reg;

  assign bus.tx_word     = result_valid_reg ? result_reg : pack_status(state_reg, flags);
  assign bus.des_key     = key_reg;
  assign bus.des_block   = block_reg;
  assign bus.des_decrypt = decrypt_reg;
  assign bus.des_start   = start_reg;

  assign busy = (state_reg == ST_START) || (state_reg == ST_BUSY);
  assign err  = err_timeout_reg | err_proto_reg;

endmodule
